// File: rtl/lfsr_req_sequencer.sv
// lfsr_req_sequencer: seed load / warm-up sequencing and round-robin sharing
// of one external Galois LFSR between two requesters.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_LOAD    | drive ld with the (zero-guarded) seed, capture taps, 1 cycle
//   ST_WARMUP  | free-run the LFSR for WARMUP steps after a seed load
//   ST_IDLE    | take a pending reseed first, otherwise arbitrate requests
//   ST_STEP    | advance the LFSR S = max(cfg_steps,1) steps for the winner
//   ST_DELIVER | hold the word valid until the granted requester accepts it
module lfsr_req_sequencer #(
   parameter int unsigned    N      = 32,
   parameter logic [N-1:0]   SEED   = {N{1'b1}},
   parameter int unsigned    WARMUP = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] cfg_taps,
   input  logic [N-1:0] cfg_seed,
   input  logic         cfg_seed_wr,
   input  logic [7:0]   cfg_steps,
   input  logic [1:0]   req_i,
   output logic [1:0]   gnt_o,
   output logic         rnd_valid_o,
   input  logic         rnd_ready_i,
   output logic [N-1:0] rnd_data_o,
   output logic         busy_o,
   output logic         lfsr_en_o,
   output logic         lfsr_ld_o,
   output logic [N-1:0] lfsr_seed_o,
   output logic [N-1:0] lfsr_taps_o,
   input  logic [N-1:0] lfsr_q_i
);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_WARMUP,
      ST_IDLE,
      ST_STEP,
      ST_DELIVER
   } state_t;

   localparam logic [15:0] WARMUP_CNT = WARMUP[15:0];
   localparam bit          WARMUP_EN  = (WARMUP_CNT != 16'd0);

   state_t       state_q,  state_d;
   logic [N-1:0] seed_q,   seed_d;
   logic         pend_q,   pend_d;
   logic         rr_ptr_q, rr_ptr_d;
   logic         win_q,    win_d;
   logic [15:0]  cnt_q,    cnt_d;
   logic [1:0]   gnt_q,    gnt_d;
   logic         valid_q,  valid_d;
   logic         en_q,     en_d;
   logic         busy_q,   busy_d;
   logic [N-1:0] taps_q,   taps_d;

   logic [15:0]  steps_cnt;
   logic         arb_win;

   // Step count for a new word (0 behaves as 1) and round-robin winner.
   always_comb begin
      steps_cnt = (cfg_steps == 8'd0) ? 16'd1 : {8'd0, cfg_steps};
      if (req_i == 2'b11) arb_win = rr_ptr_q;
      else                arb_win = req_i[1];
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      pend_d   = pend_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      valid_d  = valid_q;
      en_d     = en_q;
      busy_d   = busy_q;
      taps_d   = taps_q;

      // A write during LOAD arrives after the current seed was used, so it
      // must stay pending rather than be cleared by this LOAD.
      if (cfg_seed_wr) seed_d = cfg_seed;
      if (cfg_seed_wr && (state_q != ST_IDLE)) pend_d = 1'b1;
      else if (state_q == ST_LOAD)             pend_d = 1'b0;

      case (state_q)
         ST_LOAD: begin
            taps_d = cfg_taps;
            if (WARMUP_EN) begin
               cnt_d   = WARMUP_CNT;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_WARMUP;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_WARMUP: begin
            if (cnt_q <= 16'd1) begin
               en_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_IDLE: begin
            if (pend_q || cfg_seed_wr) begin
               busy_d  = 1'b1;
               state_d = ST_LOAD;
            end else if (req_i != 2'b00) begin
               win_d   = arb_win;
               gnt_d   = arb_win ? 2'b10 : 2'b01;
               cnt_d   = steps_cnt;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (cnt_q <= 16'd1) begin
               en_d    = 1'b0;
               valid_d = 1'b1;
               state_d = ST_DELIVER;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DELIVER: begin
            if (rnd_ready_i) begin
               valid_d  = 1'b0;
               gnt_d    = 2'b00;
               rr_ptr_d = ~win_q;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            en_d    = 1'b0;
            valid_d = 1'b0;
            gnt_d   = 2'b00;
            busy_d  = 1'b1;
            state_d = ST_LOAD;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOAD;
         seed_q   <= SEED;
         pend_q   <= 1'b0;
         rr_ptr_q <= 1'b0;
         win_q    <= 1'b0;
         cnt_q    <= 16'd0;
         gnt_q    <= 2'b00;
         valid_q  <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b1;
         taps_q   <= '0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         pend_q   <= pend_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         valid_q  <= valid_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         taps_q   <= taps_d;
      end
   end

   // ld follows the LOAD state so the first load lands on the first edge
   // after reset release; it is held low while reset is asserted.
   assign lfsr_ld_o   = rst_n && (state_q == ST_LOAD);
   assign lfsr_seed_o = (seed_q == '0) ? {N{1'b1}} : seed_q;
   assign lfsr_taps_o = taps_q;
   assign lfsr_en_o   = en_q;
   assign gnt_o       = gnt_q;
   assign rnd_valid_o = valid_q;
   assign rnd_data_o  = lfsr_q_i;
   assign busy_o      = busy_q;

endmodule
